// File: rtl/zx_clkgen.sv
// Spectrum clock generator: fixed system/ULA/PSG clocks from clk_56m plus a CPU clock
// with glitch-free speed switching at rising boundaries. Optional hold: CLKGEN_HOLD_EN.
module zx_clkgen #(
    parameter int MODES = 4,
    parameter int CW    = 5,
    parameter int HALF0 = 8,
    parameter int HALF1 = 4,
    parameter int HALF2 = 2,
    parameter int HALF3 = 1,
    parameter int HALF4 = 1,
    parameter int HALF5 = 1,
    parameter int HALF6 = 1,
    parameter int HALF7 = 1,
    localparam int SW   = (MODES > 1) ? $clog2(MODES) : 1
) (
    input  logic          clk_56m,
    input  logic          nRESET,
    input  logic [SW-1:0] speed,
    input  logic          hold,
    output logic          clk_cpu,
    output logic          cpu_pos,
    output logic          cpu_neg,
    output logic          clk_sys,
    output logic          clk_ula,
    output logic          clk_psg,
    output logic [SW-1:0] cur_speed,
    output logic          busy
);

    // state | meaning
    // S_RUN  | cur_speed matches the requested mode
    // S_PEND | switch requested, waiting for the next clk_cpu rising boundary
    typedef enum logic {S_RUN, S_PEND} state_t;

    localparam int HALF_TAB [8] = '{HALF0, HALF1, HALF2, HALF3, HALF4, HALF5, HALF6, HALF7};

    state_t        state, state_nx;
    logic [4:0]    cnt;
    logic [CW-1:0] hcnt, hcnt_nx;
    logic [SW-1:0] tgt, cur_nx;
    logic [3:0]    speed_w;
    logic          clk_nx, pos_nx, neg_nx, busy_nx;
    logic          hold_act, at_tc, held, rise;

    function automatic logic [CW-1:0] reload(input logic [SW-1:0] m);
        logic [2:0] idx;
        idx = 3'(m);
        return CW'(HALF_TAB[idx] - 1);
    endfunction

`ifdef CLKGEN_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = hold & 1'b0;
`endif

    assign speed_w = 4'(speed);
    assign tgt     = (speed_w >= 4'(MODES)) ? SW'(MODES - 1) : speed;

    assign at_tc = (hcnt == '0);
    assign held  = hold_act & clk_cpu;
    assign rise  = at_tc & ~clk_cpu;

    always_ff @(posedge clk_56m) begin
        if (!nRESET)
            cnt <= '0;
        else
            cnt <= cnt + 5'd1;
    end

    assign clk_sys = cnt[0];
    assign clk_ula = cnt[1];
    assign clk_psg = cnt[4];

    always_ff @(posedge clk_56m) begin
        if (!nRESET) begin
            state     <= S_RUN;
            hcnt      <= CW'(HALF0 - 1);
            clk_cpu   <= 1'b0;
            cpu_pos   <= 1'b0;
            cpu_neg   <= 1'b0;
            cur_speed <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            hcnt      <= hcnt_nx;
            clk_cpu   <= clk_nx;
            cpu_pos   <= pos_nx;
            cpu_neg   <= neg_nx;
            cur_speed <= cur_nx;
            busy      <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        clk_nx   = clk_cpu;
        pos_nx   = 1'b0;
        neg_nx   = 1'b0;
        cur_nx   = cur_speed;
        busy_nx  = busy;

        // A held high phase parks the divider at terminal count.
        if (!at_tc) begin
            hcnt_nx = hcnt - 1'b1;
        end else if (!held) begin
            clk_nx  = ~clk_cpu;
            pos_nx  = ~clk_cpu;
            neg_nx  = clk_cpu;
            hcnt_nx = reload(cur_speed);
        end

        case (state)
            S_RUN: begin
                if (tgt != cur_speed) begin
                    state_nx = S_PEND;
                    busy_nx  = 1'b1;
                end
            end
            S_PEND: begin
                // The new mode's first phase is a full high phase of that mode.
                if (rise) begin
                    state_nx = S_RUN;
                    busy_nx  = 1'b0;
                    cur_nx   = tgt;
                    hcnt_nx  = reload(tgt);
                end
            end
            default: state_nx = S_RUN;
        endcase
    end

endmodule

// File: tb/tb_zx_clkgen.sv
// Bench for zx_clkgen: per-cycle comparison against a phase-end model, directed
// scenarios followed by random speed/hold/reset traffic.
module tb_zx_clkgen;
    localparam int MODES = 4;
    localparam int SW    = 2;
`ifdef CLKGEN_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    int HALF_T [4] = '{8, 4, 2, 1};

    logic          clk_56m = 1'b0;
    logic          nRESET  = 1'b0;
    logic [SW-1:0] speed   = '0;
    logic          hold    = 1'b0;
    logic          clk_cpu, cpu_pos, cpu_neg, clk_sys, clk_ula, clk_psg, busy;
    logic [SW-1:0] cur_speed;

    zx_clkgen dut (
        .clk_56m  (clk_56m),
        .nRESET   (nRESET),
        .speed    (speed),
        .hold     (hold),
        .clk_cpu  (clk_cpu),
        .cpu_pos  (cpu_pos),
        .cpu_neg  (cpu_neg),
        .clk_sys  (clk_sys),
        .clk_ula  (clk_ula),
        .clk_psg  (clk_psg),
        .cur_speed(cur_speed),
        .busy     (busy)
    );

    always #5 clk_56m = ~clk_56m;

    int tests = 0;
    int fails = 0;

    // model: n counts edges since reset; the CPU clock level flips at ph_end
    int n = 0, ph_end = 8, m_level = 0, m_mode = 0, m_pend = 0, m_pos = 0, m_neg = 0;
    int g = 0, last_rise = -1, last_fall = -1, dut_period = -1, dut_high = -1, dut_low = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int tgt, pend_before, mode_before;
        bit rise;
        logic [31:0] nn;
        logic [9:0] expv, obsv;
        logic [SW-1:0] mm;
        @(posedge clk_56m);
        if (!nRESET) begin
            n = 0; ph_end = HALF_T[0]; m_level = 0; m_mode = 0; m_pend = 0;
            m_pos = 0; m_neg = 0; last_rise = -1; last_fall = -1;
        end else begin
            n++;
            m_pos = 0; m_neg = 0; rise = 1'b0;
            pend_before = m_pend; mode_before = m_mode;
            tgt = (int'(speed) > MODES - 1) ? MODES - 1 : int'(speed);
            if (n == ph_end) begin
                if (m_level == 1 && HOLD_ON && hold) begin
                    ph_end = n + 1;
                end else begin
                    m_level = 1 - m_level;
                    if (m_level == 1) begin m_pos = 1; rise = 1'b1; end
                    else m_neg = 1;
                    if (rise && pend_before == 1) m_mode = tgt;
                    ph_end = n + HALF_T[m_mode];
                end
            end
            if (pend_before == 1 && rise) m_pend = 0;
            else if (pend_before == 0 && tgt != mode_before) m_pend = 1;
        end
        @(negedge clk_56m);
        g++;
        nn = 32'(n);
        mm = SW'(m_mode);
        expv = {m_level[0], m_pos[0], m_neg[0], nn[0], nn[1], nn[4], mm, m_pend[0], 1'b0};
        obsv = {clk_cpu, cpu_pos, cpu_neg, clk_sys, clk_ula, clk_psg, cur_speed, busy, 1'b0};
        check("cycle", 32'(obsv), 32'(expv));
        if (cpu_pos) begin
            if (last_rise >= 0) dut_period = g - last_rise;
            if (last_fall >= 0) dut_low = g - last_fall;
            last_rise = g;
        end
        if (cpu_neg) begin
            if (last_rise >= 0) dut_high = g - last_rise;
            last_fall = g;
        end
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic wait_pos(input string tag);
        int i;
        i = 0;
        do begin step(); i++; end while (!cpu_pos && i < 64);
        check(tag, 32'(cpu_pos), 32'd1);
    endtask

    task automatic wait_neg(input string tag);
        int i;
        i = 0;
        do begin step(); i++; end while (!cpu_neg && i < 64);
        check(tag, 32'(cpu_neg), 32'd1);
    endtask

    initial begin
        int negs, highs;

        // reset state
        nRESET = 1'b0;
        steps(2);
        check("reset_outs", 32'({clk_cpu, cpu_pos, cpu_neg, clk_sys, clk_ula, clk_psg, cur_speed, busy}), 32'd0);
        nRESET = 1'b1;

        // mode 0 timing; first rise HALF0 cycles after release
        steps(7);
        check("first_rise_early", 32'(clk_cpu), 32'd0);
        step();
        check("first_rise", 32'(cpu_pos), 32'd1);
        wait_pos("m0_pos1");
        wait_neg("m0_neg");
        wait_pos("m0_pos2");
        check("m0_period", 32'(dut_period), 32'd16);
        check("m0_high", 32'(dut_high), 32'd8);
        check("m0_low", 32'(dut_low), 32'd8);

        // 0 -> 2 requested 3 cycles into a low phase
        wait_neg("sw02_neg");
        steps(2);
        speed = 2'd2;
        step();
        check("sw02_busy", 32'(busy), 32'd1);
        check("sw02_cur_old", 32'(cur_speed), 32'd0);
        wait_pos("sw02_rise");
        check("sw02_cur", 32'(cur_speed), 32'd2);
        check("sw02_busy_clr", 32'(busy), 32'd0);
        check("sw02_low", 32'(dut_low), 32'd8);
        steps(12);
        check("m2_period", 32'(dut_period), 32'd4);

        // 3 -> 0 and a request withdrawn inside PEND
        speed = 2'd3;
        wait_pos("sw3_a");
        wait_pos("sw3_b");
        steps(6);
        check("m3_cur", 32'(cur_speed), 32'd3);
        check("m3_period", 32'(dut_period), 32'd2);
        speed = 2'd0;
        wait_pos("sw30_rise");
        check("sw30_cur", 32'(cur_speed), 32'd0);
        wait_neg("sw30_neg");
        check("sw30_high", 32'(dut_high), 32'd8);
        speed = 2'd1;
        step();
        check("tog_busy", 32'(busy), 32'd1);
        speed = 2'd0;
        step();
        for (int i = 0; i < 40 && busy; i++) step();
        check("tog_busy_clr", 32'(busy), 32'd0);
        check("tog_cur", 32'(cur_speed), 32'd0);

        // reset aborts a pending switch
        speed = 2'd2;
        step();
        check("rst_pend_busy", 32'(busy), 32'd1);
        nRESET = 1'b0;
        step();
        check("rst_pend_outs", 32'({clk_cpu, clk_sys, clk_ula, clk_psg, cur_speed, busy}), 32'd0);
        speed = 2'd0;
        nRESET = 1'b1;

`ifdef CLKGEN_HOLD_EN
        wait_pos("hold_rise");
        steps(2);
        hold = 1'b1;
        negs = 0; highs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpu_neg) negs++;
            if (clk_cpu) highs++;
        end
        hold = 1'b0;
        check("hold_no_neg", 32'(negs), 32'd0);
        check("hold_high", 32'(highs), 32'd20);
        step();
        check("hold_release_neg", 32'(cpu_neg), 32'd1);
        wait_pos("hold_next_rise");
        check("hold_low", 32'(dut_low), 32'd8);
`else
        hold = 1'b1;
        wait_pos("nohold_a");
        wait_neg("nohold_neg");
        check("nohold_high", 32'(dut_high), 32'd8);
        wait_pos("nohold_b");
        check("nohold_period", 32'(dut_period), 32'd16);
        hold = 1'b0;
        negs = 0; highs = 0;
`endif

        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) speed = SW'($urandom_range(0, MODES - 1));
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            nRESET = ($urandom_range(0, 399) != 0);
            step();
        end
        nRESET = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
